dsp_alu_sched: RTL and testbench

- Time-multiplexes one 48-bit DSP add/sub datapath among `num_req` requesters.
- Per cycle, a round-robin arbiter accepts at most one operation. It registers the operands and ALU mode toward the DSP, and tracks each issued operation's requester id through the DSP pipeline.
- Returns each result with that id after a fixed latency.
- Sits between requester logic and a single DSP48E2 configured as C ± (A:B) (OPMODE 9'b000110011). Provides a flush handshake so the DSP can be quiesced before reconfiguration.

---
 rtl/dsp_sched_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/dsp_alu_sched.sv | 153 +++++++++++++++
 tb/tb_dsp_alu_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_sched_pkg.sv
// Shared types and DSP48E2 control constants for the add/sub scheduler.
// OPMODE_ADDSUB is the static OPMODE the DSP wrapper ties off for C +/- (A:B).
package dsp_sched_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ALUMODE_ADD   = 4'b0000;
    localparam logic [3:0] ALUMODE_SUB   = 4'b0011;
    localparam logic [8:0] OPMODE_ADDSUB = 9'b000110011;

    function automatic logic [3:0] alumode_of(input op_t op);
        return (op == SUB) ? ALUMODE_SUB : ALUMODE_ADD;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the request vector,
// priority pointer advances past the winner only on an accepted transfer.
module rr_arbiter #(
    parameter int unsigned num_req = 4,
    localparam int unsigned IdW = $clog2(num_req)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic [num_req-1:0] req,
    output logic [num_req-1:0] gnt,
    output logic               accept,
    output logic [IdW-1:0]     gnt_id
);

    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] cand;

    always_comb begin
        gnt    = '0;
        accept = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            cand = IdW'((32'(ptr_q) + i) % num_req);
            if (en && !accept && req[cand]) begin
                gnt[cand] = 1'b1;
                accept    = 1'b1;
                gnt_id    = cand;
            end
        end
        ptr_d = accept ? IdW'((32'(gnt_id) + 32'd1) % num_req) : ptr_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dsp_alu_sched.sv
// Shares one DSP48E2 add/sub datapath among num_req requesters: registers the
// granted operands toward the DSP and returns each result tagged with its id.
module dsp_alu_sched
    import dsp_sched_pkg::*;
#(
    parameter int unsigned width   = 48,
    parameter int unsigned num_req = 4,
    parameter int unsigned latency = 1,
    localparam int unsigned IdW  = $clog2(num_req),
    localparam int unsigned CntW = $clog2(latency + 2)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [num_req-1:0]       req_valid,
    output logic [num_req-1:0]       req_ready,
    input  logic [num_req-1:0]       req_op,
    input  logic [num_req*width-1:0] req_a,
    input  logic [num_req*width-1:0] req_b,
    output logic [3:0]               dsp_alumode,
    output logic [width-1:0]         dsp_c,
    output logic [width-1:0]         dsp_ab,
    input  logic [width-1:0]         dsp_y,
    output logic                     resp_valid,
    output logic [IdW-1:0]           resp_id,
    output logic [width-1:0]         resp_y,
    output logic [CntW-1:0]          in_flight,
    input  logic                     flush,
    output logic                     flush_done
);

    if (width < 1 || width > 48) begin : g_bad_width
        $error("dsp_alu_sched: width must be 1..48");
    end
    if (num_req < 2 || num_req > 8) begin : g_bad_num_req
        $error("dsp_alu_sched: num_req must be 2..8");
    end
    if (latency > 4) begin : g_bad_latency
        $error("dsp_alu_sched: latency must be 0..4");
    end

    logic [width-1:0] a_arr [num_req];
    logic [width-1:0] b_arr [num_req];

    for (genvar g = 0; g < num_req; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*width +: width];
        assign b_arr[g] = req_b[g*width +: width];
    end

    state_t                       state_q, state_d;
    logic   [width-1:0]           c_q, c_d;
    logic   [width-1:0]           ab_q, ab_d;
    logic   [3:0]                 alumode_q, alumode_d;
    // Stage 0 is the issue stage (aligned with dsp_*), stage `latency` is the output.
    logic   [latency:0]           tag_vld_q, tag_vld_d;
    logic   [latency:0][IdW-1:0]  tag_id_q, tag_id_d;
    logic   [CntW-1:0]            cnt_q, cnt_d;

    logic               arb_en;
    logic               accept;
    logic [IdW-1:0]     grant_id;

    // Grants stop in the very cycle flush rises, and during a reset cycle.
    assign arb_en = reset && !flush && (state_q == RUN);

    rr_arbiter #(
        .num_req (num_req)
    ) u_arb (
        .clock  (clock),
        .reset  (reset),
        .en     (arb_en),
        .req    (req_valid),
        .gnt    (req_ready),
        .accept (accept),
        .gnt_id (grant_id)
    );

    always_comb begin
        c_d       = c_q;
        ab_d      = ab_q;
        alumode_d = alumode_q;
        if (accept) begin
            c_d       = a_arr[grant_id];
            ab_d      = b_arr[grant_id];
            alumode_d = alumode_of(op_t'(req_op[grant_id]));
        end

        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = accept;
        tag_id_d[0]  = accept ? grant_id : '0;
        for (int unsigned i = 1; i <= latency; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        cnt_d = cnt_q;
        case ({accept, resp_valid})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (!flush) begin
                    state_d = RUN;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!flush) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= RUN;
            c_q       <= '0;
            ab_q      <= '0;
            alumode_q <= ALUMODE_ADD;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            ab_q      <= ab_d;
            alumode_q <= alumode_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dsp_c       = c_q;
    assign dsp_ab      = ab_q;
    assign dsp_alumode = alumode_q;
    assign resp_valid  = tag_vld_q[latency];
    assign resp_id     = tag_id_q[latency];
    assign resp_y      = dsp_y;
    assign in_flight   = cnt_q;
    assign flush_done  = (state_q == DONE);

endmodule

// File: tb/tb_dsp_alu_sched.sv
// Drives three schedulers (latency 0, 1, 4) with shared stimulus and checks them
// against a transaction-level scoreboard and behavioural DSP models.
module tb_dsp_alu_sched;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int NI = 3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 4);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           flush;

    logic [N-1:0] ready_w [NI];
    logic [3:0]   alu_w   [NI];
    logic [W-1:0] c_w     [NI];
    logic [W-1:0] ab_w    [NI];
    logic [W-1:0] ry_w    [NI];
    logic         rv_w    [NI];
    logic [1:0]   rid_w   [NI];
    logic [2:0]   infl_w  [NI];
    logic         fd_w    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L  = (g == 0) ? 0 : ((g == 1) ? 1 : 4);
        localparam int unsigned CW = $clog2(L + 2);
        logic [CW-1:0] infl;
        logic [W-1:0]  y;
        logic [W-1:0]  raw;

        dsp_alu_sched #(
            .width   (W),
            .num_req (N),
            .latency (L)
        ) u_dut (
            .clock       (clk),
            .reset       (rst_n),
            .req_valid   (req_valid),
            .req_ready   (ready_w[g]),
            .req_op      (req_op),
            .req_a       (req_a),
            .req_b       (req_b),
            .dsp_alumode (alu_w[g]),
            .dsp_c       (c_w[g]),
            .dsp_ab      (ab_w[g]),
            .dsp_y       (y),
            .resp_valid  (rv_w[g]),
            .resp_id     (rid_w[g]),
            .resp_y      (ry_w[g]),
            .in_flight   (infl),
            .flush       (flush),
            .flush_done  (fd_w[g])
        );
        assign infl_w[g] = 3'(infl);

        // Behavioural DSP: P = C - (A:B) for ALUMODE 0011, else C + (A:B).
        assign raw = (alu_w[g] == 4'b0011) ? (c_w[g] - ab_w[g]) : (c_w[g] + ab_w[g]);
        if (L == 0) begin : g_comb
            assign y = raw;
        end else begin : g_pipe
            logic [W-1:0] p [L];
            always @(posedge clk) begin
                p[0] <= raw;
                for (int i = 1; i < int'(L); i++) p[i] <= p[i-1];
            end
            assign y = p[L-1];
        end
    end

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] y;
    } rsp_t;

    rsp_t         sb [NI][$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           ptr = 0;
    int           run = 0;
    bit           prev_flush = 1'b0;
    bit           armed [NI];
    int           infl_seen [NI];
    logic [W-1:0] exp_c, exp_ab;
    logic [3:0]   exp_alu;
    logic [W-1:0] va [N];
    logic [W-1:0] vb [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, want);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = va[i];
            req_b[i*W +: W] = vb[i];
        end
    endtask

    // Grant rule: only when not in reset, flush low now and in the previous cycle.
    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] gnt;
        gnt = '0;
        if (!rst_n || flush || prev_flush) return gnt;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (ptr + i) % N;
            if (req_valid[idx]) begin
                gnt[idx] = 1'b1;
                return gnt;
            end
        end
        return gnt;
    endfunction

    task automatic check_cycle();
        logic [N-1:0] eg;
        bit           ev;
        eg = exp_grant();
        for (int g = 0; g < NI; g++) begin
            int l;
            l = lat_of(g);
            chk($sformatf("req_ready L%0d", l), 64'(ready_w[g]), 64'(eg));
            chk($sformatf("dsp_c L%0d", l), 64'(c_w[g]), 64'(exp_c));
            chk($sformatf("dsp_ab L%0d", l), 64'(ab_w[g]), 64'(exp_ab));
            chk($sformatf("dsp_alumode L%0d", l), 64'(alu_w[g]), 64'(exp_alu));
            chk($sformatf("in_flight L%0d", l), 64'(infl_w[g]), 64'(sb[g].size()));
            infl_seen[g] = sb[g].size();
            chk($sformatf("flush_done L%0d", l), 64'(fd_w[g]), 64'(armed[g]));
            ev = (sb[g].size() > 0) && (sb[g][0].due == cyc);
            chk($sformatf("resp_valid L%0d", l), 64'(rv_w[g]), 64'(ev));
            if (ev) begin
                chk($sformatf("resp_id L%0d", l), 64'(rid_w[g]), 64'(sb[g][0].id));
                chk($sformatf("resp_y L%0d", l), 64'(ry_w[g]), 64'(sb[g][0].y));
                void'(sb[g].pop_front());
            end
        end
    endtask

    task automatic update_model();
        logic [N-1:0] eg;
        int           id;
        logic [W-1:0] a, b, y;
        eg = exp_grant();
        if (!rst_n) begin
            for (int g = 0; g < NI; g++) begin
                sb[g].delete();
                armed[g] = 1'b0;
            end
            ptr        = 0;
            run        = 0;
            prev_flush = 1'b0;
            exp_c      = '0;
            exp_ab     = '0;
            exp_alu    = 4'b0000;
        end else begin
            id = -1;
            for (int i = 0; i < N; i++) if (eg[i]) id = i;
            if (id >= 0) begin
                a = va[id];
                b = vb[id];
                y = req_op[id] ? (a - b) : (a + b);
                for (int g = 0; g < NI; g++) begin
                    sb[g].push_back('{due: cyc + 1 + lat_of(g), id: id, y: y});
                end
                exp_c   = a;
                exp_ab  = b;
                exp_alu = req_op[id] ? 4'b0011 : 4'b0000;
                ptr     = (id + 1) % N;
            end
            run = flush ? run + 1 : 0;
            for (int g = 0; g < NI; g++) begin
                if (!flush) armed[g] = 1'b0;
                else if (run >= 2 && infl_seen[g] == 0) armed[g] = 1'b1;
            end
            prev_flush = flush;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        for (int i = 0; i < N; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end
        pack();
        for (int g = 0; g < NI; g++) begin
            armed[g]     = 1'b0;
            infl_seen[g] = 0;
        end
        @(posedge clk);
        update_model();
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        idle(2);

        // Single add from requester 2.
        va[2] = 16'd5; vb[2] = 16'd7; req_op = 4'b0000; pack();
        req_valid = 4'b0100;
        tick();
        idle(6);

        // Subtraction wrapping modulo 2^16.
        va[0] = 16'd3; vb[0] = 16'd5; req_op = 4'b0001; pack();
        req_valid = 4'b0001;
        tick();
        idle(6);

        // Contention among requesters 0, 1, 3.
        for (int i = 0; i < N; i++) begin
            va[i] = W'(16'h100 * (i + 1));
            vb[i] = W'(i + 9);
        end
        req_op = 4'b1010; pack();
        req_valid = 4'b1011;
        for (int i = 0; i < 9; i++) tick();
        idle(6);

        // Flush while streaming, then resume.
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        idle(6);

        // Reset one cycle after an accept drops the operation.
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst resp_id L%0d", lat_of(g)), 64'(rid_w[g]), 64'd0);
            chk($sformatf("rst resp_valid L%0d", lat_of(g)), 64'(rv_w[g]), 64'd0);
            chk($sformatf("rst in_flight L%0d", lat_of(g)), 64'(infl_w[g]), 64'd0);
            chk($sformatf("rst dsp_c L%0d", lat_of(g)), 64'(c_w[g]), 64'd0);
        end
        idle(8);

        // Randomized traffic with occasional flush and reset.
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 24) == 0) flush = ~flush;
            req_valid = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            req_op    = N'($urandom);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 7))
                    0:       va[i] = '0;
                    1:       va[i] = '1;
                    default: va[i] = W'($urandom);
                endcase
                case ($urandom_range(0, 7))
                    0:       vb[i] = '0;
                    1:       vb[i] = '1;
                    default: vb[i] = W'($urandom);
                endcase
            end
            pack();
            tick();
        end

        rst_n = 1'b1;
        flush = 1'b0;
        idle(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
